// File: rtl/ps2_key_fifo_if.sv
// Key-event port bundle between the PS/2 receiver / CPU side and ps2_key_fifo.
// The master side feeds received bytes and pops; the slave side is the decoder/FIFO.
interface ps2_key_fifo_if #(
  parameter int AW = 3
) ();
  logic [7:0]  ps2_byte;
  logic        ps2_ready;
  logic        rd_en;
  logic        clr_ovf;
  logic [9:0]  key_out;
  logic        key_valid;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic        proto_err;

  modport master (
    output ps2_byte, ps2_ready, rd_en, clr_ovf,
    input  key_out, key_valid, full, count, overflow, proto_err
  );

  modport slave (
    input  ps2_byte, ps2_ready, rd_en, clr_ovf,
    output key_out, key_valid, full, count, overflow, proto_err
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code decoder plus first-word-fall-through key-event FIFO.
// Bytes are folded into {brk, ext, code} events by a small prefix FSM and queued
// for the CPU; the head entry is presented from a register so key_out never
// depends combinationally on the incoming byte.
module ps2_key_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int TIMEOUT_W = 20
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_fifo_if.slave  bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [TIMEOUT_W-1:0] tmo_reg, tmo_next;

  // Decoder results for this cycle
  logic       push;
  logic [9:0] push_data;
  logic       err_set;

  logic is_e0, is_f0, is_ignored;
  assign is_e0      = (bus.ps2_byte == 8'hE0);
  assign is_f0      = (bus.ps2_byte == 8'hF0);
  // Keyboard status/ack bytes carry no key information when no prefix is pending
  assign is_ignored = (bus.ps2_byte == 8'hAA) || (bus.ps2_byte == 8'hFA) ||
                      (bus.ps2_byte == 8'hEE) || (bus.ps2_byte == 8'hFE) ||
                      (bus.ps2_byte == 8'h00) || (bus.ps2_byte == 8'hFF);

  // FSM state and prefix-timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
    end
  end

  // Next-state decode: prefix tracking, event emission and stale-prefix timeout
  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    push       = 1'b0;
    push_data  = {2'b00, bus.ps2_byte};
    err_set    = 1'b0;
    if (bus.ps2_ready) begin
      tmo_next = '0;
      case (state_reg)
        S_IDLE: begin
          if (is_e0)            state_next = S_EXT;
          else if (is_f0)       state_next = S_BRK;
          else if (!is_ignored) push = 1'b1;
        end
        S_EXT: begin
          if (is_f0) begin
            state_next = S_EXTBRK;
          end else if (!is_e0) begin
            push       = 1'b1;
            push_data  = {2'b01, bus.ps2_byte};
            state_next = S_IDLE;
          end
        end
        S_BRK: begin
          state_next = S_IDLE;
          if (is_e0 || is_f0) begin
            err_set = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {2'b10, bus.ps2_byte};
          end
        end
        S_EXTBRK: begin
          state_next = S_IDLE;
          if (is_e0 || is_f0) begin
            err_set = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {2'b11, bus.ps2_byte};
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state_reg != S_IDLE) begin
      // A prefix with no follow-up byte is abandoned silently
      if (&tmo_reg) begin
        state_next = S_IDLE;
        tmo_next   = '0;
      end else begin
        tmo_next = tmo_reg + 1'b1;
      end
    end else begin
      tmo_next = '0;
    end
  end

  // FIFO storage and bookkeeping
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [9:0]    head_reg, head_next;
  logic          ovf_reg, err_reg;
  logic          do_pop, do_push, drop;

  assign do_pop  = bus.rd_en && (count_reg != '0);
  // At full a push still fits when the head leaves in the same cycle
  assign do_push = push && ((count_reg != DEPTH_CNT) || do_pop);
  assign drop    = push && (count_reg == DEPTH_CNT) && !do_pop;

  // Pointer, count and next-head computation
  always_comb begin
    rd_ptr_next = do_pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    wr_ptr_next = do_push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    count_next  = count_reg;
    if (do_push && !do_pop)      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push) count_next = count_reg - 1'b1;
    // The new head may be the entry being written this very cycle
    if (count_next == '0)
      head_next = 10'h000;
    else if (do_push && (wr_ptr_reg == rd_ptr_next))
      head_next = push_data;
    else
      head_next = mem[rd_ptr_next];
  end

  // Entry storage; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers, count, registered head and sticky status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= 10'h000;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      if (drop)             ovf_reg <= 1'b1;
      else if (bus.clr_ovf) ovf_reg <= 1'b0;
      if (err_set)          err_reg <= 1'b1;
      else if (bus.clr_ovf) err_reg <= 1'b0;
    end
  end

  assign bus.key_out   = head_reg;
  assign bus.key_valid = (count_reg != '0);
  assign bus.full      = (count_reg == DEPTH_CNT);
  assign bus.count     = count_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.proto_err = err_reg;

endmodule
